// File: rtl/fpu_round_pack.sv
// Normalise / round / pack stage for FPU results: three valid/ready pipeline stages
// turning an unnormalised sign/exponent/significand into a packed IEEE-754 word plus flags.
module fpu_round_pack #(
    parameter int EXPONENT_WIDTH    = 11,
    parameter int SIGNIFICAND_WIDTH = 52,
    parameter int PACKED_WIDTH      = 1 + EXPONENT_WIDTH + SIGNIFICAND_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sign,
    input  logic [EXPONENT_WIDTH+1:0]    in_exponent,
    input  logic [SIGNIFICAND_WIDTH+3:0] in_significand,
    input  logic [1:0]                   in_rmode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PACKED_WIDTH-1:0]      out_packed,
    output logic                         out_overflow,
    output logic                         out_underflow,
    output logic                         out_inexact
);

    localparam int EW  = EXPONENT_WIDTH;
    localparam int SW  = SIGNIFICAND_WIDTH;
    localparam int XW  = EW + 2;
    localparam int MW  = SW + 1;
    localparam int NW  = SW + 3;
    localparam int LZW = $clog2(NW + 1);

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RUP = 2'd2;
    localparam logic [1:0] RM_RDN = 2'd3;

    localparam logic [XW-1:0] EXP_INF = XW'((1 << EW) - 1);

    logic s3_load, s2_load, s1_load;

    logic           s1_valid_q, s1_valid_d;
    logic           s1_sign_q, s1_sign_d;
    logic [XW-1:0]  s1_exp_q, s1_exp_d;
    logic [MW-1:0]  s1_mant_q, s1_mant_d;
    logic           s1_guard_q, s1_guard_d;
    logic           s1_sticky_q, s1_sticky_d;
    logic [1:0]     s1_rmode_q, s1_rmode_d;

    logic           s2_valid_q, s2_valid_d;
    logic           s2_sign_q, s2_sign_d;
    logic [XW-1:0]  s2_exp_q, s2_exp_d;
    logic [SW-1:0]  s2_frac_q, s2_frac_d;
    logic           s2_zero_q, s2_zero_d;
    logic           s2_inexact_q, s2_inexact_d;
    logic [1:0]     s2_rmode_q, s2_rmode_d;

    logic                    s3_valid_q, s3_valid_d;
    logic [PACKED_WIDTH-1:0] s3_packed_q, s3_packed_d;
    logic                    s3_overflow_q, s3_overflow_d;
    logic                    s3_underflow_q, s3_underflow_d;
    logic                    s3_inexact_q, s3_inexact_d;

    logic [LZW-1:0] lz;
    logic [NW-1:0]  norm;
    logic           inc;
    logic           grs;
    logic [MW:0]    sum;
    logic           away;
    logic           exp_high;
    logic           exp_low;

    // A stage can take new data when it is empty or its contents move on this cycle.
    always_comb begin
        s3_load  = !s3_valid_q || out_ready;
        s2_load  = !s2_valid_q || s3_load;
        s1_load  = !s1_valid_q || s2_load;
        in_ready = !rst && s1_load;
    end

    always_comb begin
        lz = '0;
        for (int i = 0; i < NW; i++) begin
            if (in_significand[i]) lz = LZW'(NW - 1 - i);
        end
        norm = in_significand[NW-1:0] << lz;

        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_exp_d    = s1_exp_q;
        s1_mant_d   = s1_mant_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        s1_rmode_d  = s1_rmode_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            s1_sign_d  = in_sign;
            s1_rmode_d = in_rmode;
            if (in_significand[NW]) begin
                s1_exp_d    = in_exponent + XW'(1);
                s1_mant_d   = in_significand[NW:3];
                s1_guard_d  = in_significand[2];
                s1_sticky_d = in_significand[1] || in_significand[0];
            end else begin
                s1_exp_d    = in_exponent - XW'(lz);
                s1_mant_d   = norm[NW-1:2];
                s1_guard_d  = norm[1];
                s1_sticky_d = norm[0];
            end
        end
    end

    // A zero significand keeps a clear hidden bit through rounding, so it doubles as the zero marker.
    always_comb begin
        grs = s1_guard_q || s1_sticky_q;
        case (s1_rmode_q)
            RM_RNE:  inc = s1_guard_q && (s1_sticky_q || s1_mant_q[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = !s1_sign_q && grs;
            default: inc = s1_sign_q && grs;
        endcase
        sum = {1'b0, s1_mant_q} + {{MW{1'b0}}, inc};

        s2_valid_d   = s2_valid_q;
        s2_sign_d    = s2_sign_q;
        s2_exp_d     = s2_exp_q;
        s2_frac_d    = s2_frac_q;
        s2_zero_d    = s2_zero_q;
        s2_inexact_d = s2_inexact_q;
        s2_rmode_d   = s2_rmode_q;
        if (s2_load) begin
            s2_valid_d   = s1_valid_q;
            s2_sign_d    = s1_sign_q;
            s2_rmode_d   = s1_rmode_q;
            s2_inexact_d = grs;
            s2_zero_d    = !(sum[MW] || sum[SW]);
            if (sum[MW]) begin
                s2_exp_d  = s1_exp_q + XW'(1);
                s2_frac_d = '0;
            end else begin
                s2_exp_d  = s1_exp_q;
                s2_frac_d = sum[SW-1:0];
            end
        end
    end

    always_comb begin
        away = (s2_rmode_q == RM_RNE)
            || (s2_rmode_q == RM_RUP && !s2_sign_q)
            || (s2_rmode_q == RM_RDN && s2_sign_q);
        exp_high = !s2_exp_q[XW-1] && (s2_exp_q >= EXP_INF);
        exp_low  = s2_exp_q[XW-1] || (s2_exp_q == '0);

        s3_valid_d     = s3_valid_q;
        s3_packed_d    = s3_packed_q;
        s3_overflow_d  = s3_overflow_q;
        s3_underflow_d = s3_underflow_q;
        s3_inexact_d   = s3_inexact_q;
        if (s3_load) begin
            s3_valid_d     = s2_valid_q;
            s3_overflow_d  = 1'b0;
            s3_underflow_d = 1'b0;
            s3_inexact_d   = 1'b0;
            if (s2_zero_q) begin
                s3_packed_d = {s2_sign_q, {(PACKED_WIDTH-1){1'b0}}};
            end else if (exp_high) begin
                s3_overflow_d = 1'b1;
                s3_inexact_d  = 1'b1;
                if (away) s3_packed_d = {s2_sign_q, {EW{1'b1}}, {SW{1'b0}}};
                else      s3_packed_d = {s2_sign_q, {(EW-1){1'b1}}, 1'b0, {SW{1'b1}}};
            end else if (exp_low) begin
                s3_underflow_d = 1'b1;
                s3_inexact_d   = 1'b1;
                s3_packed_d    = {s2_sign_q, {(PACKED_WIDTH-1){1'b0}}};
            end else begin
                s3_inexact_d = s2_inexact_q;
                s3_packed_d  = {s2_sign_q, s2_exp_q[EW-1:0], s2_frac_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_sign_q      <= 1'b0;
            s1_exp_q       <= '0;
            s1_mant_q      <= '0;
            s1_guard_q     <= 1'b0;
            s1_sticky_q    <= 1'b0;
            s1_rmode_q     <= '0;
            s2_valid_q     <= 1'b0;
            s2_sign_q      <= 1'b0;
            s2_exp_q       <= '0;
            s2_frac_q      <= '0;
            s2_zero_q      <= 1'b0;
            s2_inexact_q   <= 1'b0;
            s2_rmode_q     <= '0;
            s3_valid_q     <= 1'b0;
            s3_packed_q    <= '0;
            s3_overflow_q  <= 1'b0;
            s3_underflow_q <= 1'b0;
            s3_inexact_q   <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_sign_q      <= s1_sign_d;
            s1_exp_q       <= s1_exp_d;
            s1_mant_q      <= s1_mant_d;
            s1_guard_q     <= s1_guard_d;
            s1_sticky_q    <= s1_sticky_d;
            s1_rmode_q     <= s1_rmode_d;
            s2_valid_q     <= s2_valid_d;
            s2_sign_q      <= s2_sign_d;
            s2_exp_q       <= s2_exp_d;
            s2_frac_q      <= s2_frac_d;
            s2_zero_q      <= s2_zero_d;
            s2_inexact_q   <= s2_inexact_d;
            s2_rmode_q     <= s2_rmode_d;
            s3_valid_q     <= s3_valid_d;
            s3_packed_q    <= s3_packed_d;
            s3_overflow_q  <= s3_overflow_d;
            s3_underflow_q <= s3_underflow_d;
            s3_inexact_q   <= s3_inexact_d;
        end
    end

    // Outputs read as idle for the whole time reset is held, not just after the first edge.
    always_comb begin
        out_valid     = s3_valid_q && !rst;
        out_packed    = rst ? '0 : s3_packed_q;
        out_overflow  = s3_overflow_q && !rst;
        out_underflow = s3_underflow_q && !rst;
        out_inexact   = s3_inexact_q && !rst;
    end

endmodule

// File: tb/tb_fpu_round_pack.sv
// Bench for fpu_round_pack (double precision): directed literals, backpressure, reset,
// and random beats scored against an exact integer rounding model.
module tb_fpu_round_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [12:0] in_exponent;
    logic [55:0] in_significand;
    logic [1:0]  in_rmode;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_packed;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int total = 0;
    int bad   = 0;
    logic [66:0] exp_q[$];

    fpu_round_pack dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exponent   (in_exponent),
        .in_significand(in_significand),
        .in_rmode      (in_rmode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_packed    (out_packed),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    always #5 clk = ~clk;

    // Exact value model: keep the top 53 significant bits, round the discarded remainder, then range-check.
    function automatic logic [66:0] refModel(input logic sgn, input logic [12:0] e_in,
                                             input logic [55:0] sig, input logic [1:0] rm);
        int p, e, sh;
        logic [63:0] keep, rem, half, pk;
        logic up, ov, un, inx;
        if (sig == 56'd0) return {3'b000, sgn, 63'd0};
        p = 0;
        for (int i = 0; i < 56; i++) if (sig[i]) p = i;
        e = int'($signed(e_in)) + p - 54;
        if (p >= 53) begin
            sh   = p - 52;
            keep = 64'(sig) >> sh;
            rem  = 64'(sig) & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
        end else begin
            keep = 64'(sig) << (52 - p);
            rem  = 64'd0;
            half = 64'd1;
        end
        case (rm)
            2'd0:    up = (rem > half) || (rem == half && keep[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = !sgn && (rem != 0);
            default: up = sgn && (rem != 0);
        endcase
        keep = keep + 64'(up);
        if (keep == (64'd1 << 53)) begin
            keep = 64'd1 << 52;
            e    = e + 1;
        end
        inx = (rem != 0);
        ov  = 1'b0;
        un  = 1'b0;
        if (e >= 2047) begin
            ov  = 1'b1;
            inx = 1'b1;
            if (rm == 2'd0 || (rm == 2'd2 && !sgn) || (rm == 2'd3 && sgn))
                pk = {sgn, 11'h7FF, 52'd0};
            else
                pk = {sgn, 11'h7FE, {52{1'b1}}};
        end else if (e <= 0) begin
            un  = 1'b1;
            inx = 1'b1;
            pk  = {sgn, 63'd0};
        end else begin
            pk = {sgn, 11'(e), keep[51:0]};
        end
        return {ov, un, inx, pk};
    endfunction

    task automatic checkOutput(input string name, input logic [66:0] actual, input logic [66:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    // Scoreboard: every valid output beat must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_beat actual=%h required=no_beat", out_packed);
                end else begin
                    checkOutput("beat", {out_overflow, out_underflow, out_inexact, out_packed}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic setBeat(input logic sgn, input logic [12:0] e, input logic [55:0] sig, input logic [1:0] rm);
        in_sign        = sgn;
        in_exponent    = e;
        in_significand = sig;
        in_rmode       = rm;
    endtask

    task automatic applyStimulus(input string name, input logic sgn, input logic [12:0] e,
                                 input logic [55:0] sig, input logic [1:0] rm, input logic [66:0] pinned);
        logic [66:0] m;
        int lat;
        m = refModel(sgn, e, sig, rm);
        checkOutput({name, "_model"}, m, pinned);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        setBeat(sgn, e, sig, rm);
        #1;
        checkOutput({name, "_ready"}, 67'(in_ready), 67'd1);
        @(posedge clk);
        exp_q.push_back(m);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            #2;
        end
        checkOutput({name, "_latency"}, 67'(lat), 67'd3);
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        checkOutput(name, 67'(exp_q.size()), 67'd0);
    endtask

    logic [55:0] bp_sig[5];
    logic [12:0] bp_exp[5];
    logic        bp_sign[5];
    logic [1:0]  bp_rm[5];

    initial begin
        logic [63:0] held;
        logic [63:0] r;
        logic        hit;
        int          acc, stale, cycles, beats, e;
        logic        cur_sign;
        logic [12:0] cur_exp;
        logic [55:0] cur_sig;
        logic [1:0]  cur_rm;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        setBeat(1'b0, 13'd0, 56'd0, 2'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        checkOutput("reset_out", {out_overflow, out_underflow, out_inexact, out_packed}, 67'd0);
        checkOutput("reset_handshake", 67'({in_ready, out_valid}), 67'd0);
        rst = 1'b0;
        #1;
        checkOutput("reset_release_ready", 67'(in_ready), 67'd1);

        applyStimulus("hidden_only", 1'b0, 13'd1023, 56'd1 << 54, 2'd0, {3'b000, 64'h3FF0000000000000});
        applyStimulus("carry_only",  1'b0, 13'd1023, 56'd1 << 55, 2'd0, {3'b000, 64'h4000000000000000});
        applyStimulus("shift_left5", 1'b0, 13'd1028, 56'd1 << 49, 2'd0, {3'b000, 64'h3FF0000000000000});
        applyStimulus("rne_carry",   1'b0, 13'd1023, ((56'd1 << 53) - 56'd1) << 2 | 56'd2, 2'd0,
                      {3'b001, 64'h4000000000000000});
        applyStimulus("rtz_trunc",   1'b0, 13'd1023, ((56'd1 << 53) - 56'd1) << 2 | 56'd2, 2'd1,
                      {3'b001, 64'h3FFFFFFFFFFFFFFF});
        applyStimulus("rne_tie_even", 1'b0, 13'd1023, (56'd1 << 54) | 56'd2, 2'd0, {3'b001, 64'h3FF0000000000000});
        applyStimulus("ovf_rne",     1'b0, 13'd2046, 56'd1 << 55, 2'd0, {3'b101, 64'h7FF0000000000000});
        applyStimulus("ovf_rtz",     1'b0, 13'd2046, 56'd1 << 55, 2'd1, {3'b101, 64'h7FEFFFFFFFFFFFFF});
        applyStimulus("ovf_neg_rup", 1'b1, 13'd2046, 56'd1 << 55, 2'd2, {3'b101, 64'hFFEFFFFFFFFFFFFF});
        applyStimulus("underflow",   1'b1, 13'd0,    56'd1 << 54, 2'd0, {3'b011, 64'h8000000000000000});
        applyStimulus("zero",        1'b0, 13'd500,  56'd0,       2'd0, {3'b000, 64'h0000000000000000});
        waitDrain("directed_drain");

        for (int k = 0; k < 5; k++) begin
            bp_sig[k]  = (56'd1 << 54) | (56'(k + 1) << 10);
            bp_exp[k]  = 13'(1000 + k);
            bp_sign[k] = k[0];
            bp_rm[k]   = 2'(k);
        end
        @(negedge clk);
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            setBeat(bp_sign[acc], bp_exp[acc], bp_sig[acc], bp_rm[acc]);
            #1;
            hit = in_ready;
            @(posedge clk);
            if (hit) begin
                exp_q.push_back(refModel(bp_sign[acc], bp_exp[acc], bp_sig[acc], bp_rm[acc]));
                acc++;
            end
        end
        checkOutput("bp_accepted", 67'(acc), 67'd3);
        @(negedge clk);
        #1;
        checkOutput("bp_in_ready_low", 67'(in_ready), 67'd0);
        #1;
        held = out_packed;
        checkOutput("bp_out_valid", 67'(out_valid), 67'd1);
        repeat (3) @(negedge clk);
        #2;
        checkOutput("bp_stable", 67'(out_packed), 67'(held));
        for (int c = 0; c < 12 && acc < 5; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            setBeat(bp_sign[acc], bp_exp[acc], bp_sig[acc], bp_rm[acc]);
            #1;
            hit = in_ready;
            @(posedge clk);
            if (hit) begin
                exp_q.push_back(refModel(bp_sign[acc], bp_exp[acc], bp_sig[acc], bp_rm[acc]));
                acc++;
            end
        end
        checkOutput("bp_all_accepted", 67'(acc), 67'd5);
        @(negedge clk);
        in_valid = 1'b0;
        waitDrain("bp_drain");

        @(negedge clk);
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6 && acc < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            setBeat(bp_sign[acc], bp_exp[acc], bp_sig[acc], bp_rm[acc]);
            #1;
            hit = in_ready;
            @(posedge clk);
            if (hit) begin
                exp_q.push_back(refModel(bp_sign[acc], bp_exp[acc], bp_sig[acc], bp_rm[acc]));
                acc++;
            end
        end
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("rst_mid_handshake", 67'({in_ready, out_valid}), 67'd0);
        @(negedge clk);
        #1;
        checkOutput("rst_mid_outputs", {out_valid, out_overflow, out_underflow, out_inexact, out_packed[62:0]}, 67'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_release_ready", 67'(in_ready), 67'd1);
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #2;
            if (out_valid) stale++;
        end
        checkOutput("rst_mid_no_stale", 67'(stale), 67'd0);

        beats  = 0;
        cycles = 0;
        cur_sign = 1'b0; cur_exp = 13'd0; cur_sig = 56'd0; cur_rm = 2'd0;
        hit = 1'b1;
        while (beats < 300 && cycles < 4000) begin
            if (hit) begin
                r        = {$urandom(), $urandom()};
                cur_sig  = r[55:0] >> $urandom_range(0, 56);
                if ($urandom_range(0, 9) == 0) cur_sig = 56'd0;
                if ($urandom_range(0, 7) == 0) cur_sig[1:0] = 2'b10;
                case ($urandom_range(0, 3))
                    0:       e = int'($urandom_range(1, 2046));
                    1:       e = 2030 + int'($urandom_range(0, 40));
                    2:       e = int'($urandom_range(0, 120)) - 60;
                    default: e = 993 + int'($urandom_range(0, 60));
                endcase
                cur_exp  = 13'(e);
                cur_sign = 1'($urandom_range(0, 1));
                cur_rm   = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            cycles++;
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = ($urandom_range(0, 4) != 0);
            setBeat(cur_sign, cur_exp, cur_sig, cur_rm);
            #1;
            hit = in_valid && in_ready;
            @(posedge clk);
            if (hit) begin
                exp_q.push_back(refModel(cur_sign, cur_exp, cur_sig, cur_rm));
                beats++;
            end
        end
        checkOutput("random_beats_accepted", 67'(beats), 67'd300);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain("random_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
